// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA tile-fetch pipeline.
//   sel_tag_t     : per-pixel select tag carried alongside the pixel
//   BORDER_STATE  : tile state shown on border tiles (white)
//   VGA_ACTIVE_W/H: visible raster size in pixels
package vga_pkg;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    BORDER = 2'd3
  } sel_tag_t;

  localparam logic [7:0]  BORDER_STATE = 8'd7;
  localparam int unsigned VGA_ACTIVE_W = 640;
  localparam int unsigned VGA_ACTIVE_H = 480;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
//   clk   : clock
//   reset : asynchronous active-low reset, clears every stage to 0
//   din   : WIDTH-bit input
//   dout  : din delayed by DEPTH clock cycles (DEPTH >= 1)
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] sr;
  logic [DEPTH*WIDTH-1:0] sr_next;

  generate
    if (DEPTH > 1) begin : g_multi
      assign sr_next = {sr[(DEPTH-1)*WIDTH-1:0], din};
    end else begin : g_single
      assign sr_next = din;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= sr_next;
    end
  end

  assign dout = sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_tile_fetch.sv
// Maps raster position to a game-board tile, reads the tile state from the
// board RAM once per tile run, and presents it pixel-aligned with the syncs
// after a fixed 3-cycle latency.
//   clk, reset                : pixel clock, asynchronous active-low reset
//   col, row                  : raster position
//   active_in, hsync_in,
//   vsync_in                  : timing flags aligned with col/row
//   rd_addr, re, rd_data      : board RAM port (sync read, 1-cycle latency)
//   state_out                 : tile state for the pixel 3 cycles earlier
//   hsync_out, vsync_out,
//   active_out                : inputs delayed 3 cycles
// Build option: define VGA_BORDER_EN to force outer-ring tiles to
// BORDER_STATE without reading the RAM.
module vga_tile_fetch
  import vga_pkg::*;
#(
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic              active_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              re,
  input  logic [7:0]        rd_data,
  output logic [7:0]        state_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              active_out
);

  logic [9:0]  tc;
  logic [9:0]  tr;
  logic [19:0] tile_idx;
  logic [19:0] cache_idx;
  logic        cache_valid;
  logic        active_prev;
  logic        in_grid;
  logic        border;
  logic        issue;
  logic        invalidate;
  sel_tag_t    tag_s0;
  sel_tag_t    tag_s2;
  logic [7:0]  latched;
  logic [4:0]  pipe_in;
  logic [4:0]  pipe_out;

  // S0: tile decode and fetch decision
  always_comb begin
    tc       = col >> TILE_SHIFT;
    tr       = row >> TILE_SHIFT;
    tile_idx = {tr, tc};
    in_grid  = active_in && (32'(tc) < GRID_W) && (32'(tr) < GRID_H);
`ifdef VGA_BORDER_EN
    border   = in_grid && ((tc == '0) || (32'(tc) == GRID_W - 1) ||
                           (tr == '0) || (32'(tr) == GRID_H - 1));
`else
    border   = 1'b0;
`endif
    issue      = in_grid && !border && (!cache_valid || (tile_idx != cache_idx));
    invalidate = vsync_in || (active_prev && !active_in);

    tag_s0 = BLANK;
    if (in_grid) begin
      if (border)     tag_s0 = BORDER;
      else if (issue) tag_s0 = FETCH;
      else            tag_s0 = HOLD;
    end
  end

  // Fetch registers and tile cache. Invalidation wins over a same-cycle
  // issue so a vsync always forces the next in-grid pixel to re-read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re          <= 1'b0;
      rd_addr     <= '0;
      cache_idx   <= '0;
      cache_valid <= 1'b0;
      active_prev <= 1'b0;
    end else begin
      re          <= issue;
      active_prev <= active_in;
      if (issue) begin
        rd_addr   <= ADDR_W'(32'(tr) * GRID_W + 32'(tc));
        cache_idx <= tile_idx;
      end
      if (invalidate) begin
        cache_valid <= 1'b0;
      end else if (issue) begin
        cache_valid <= 1'b1;
      end
    end
  end

  // Two delay stages bring the tag level with rd_data; the output register
  // below supplies the third stage for both the state and the syncs.
  assign pipe_in = {hsync_in, vsync_in, active_in, tag_s0};

  vga_delay_line #(
    .WIDTH(5),
    .DEPTH(2)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign tag_s2 = sel_tag_t'(pipe_out[1:0]);

  // S2: output select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_out  <= '0;
      latched    <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      hsync_out  <= pipe_out[4];
      vsync_out  <= pipe_out[3];
      active_out <= pipe_out[2];
      case (tag_s2)
        FETCH: begin
          state_out <= rd_data;
          latched   <= rd_data;
        end
        HOLD:    state_out <= latched;
        BORDER:  state_out <= BORDER_STATE;
        default: state_out <= '0;
      endcase
    end
  end

endmodule
